// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU between two requesters
// Operands are registered onto the ALU on grant; the result is captured into a valid/ready response.
module alu_share_arbiter #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 8,
  parameter int OP_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(OP_LATENCY - 1);

  logic [1:0]       state;
  logic             rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             id_q;

  logic gnt_any;
  logic gnt_id;
  logic take;
  logic func_legal;
  logic cap_err;

  // With both requesters valid the pointer decides; a lone requester always wins.
  assign gnt_any    = req0_valid | req1_valid;
  assign gnt_id     = req1_valid & (~req0_valid | rr_ptr);
  assign take       = (state == ST_IDLE) & gnt_any;
  assign req0_ready = take & ~gnt_id;
  assign req1_ready = take & gnt_id;
  assign busy       = (state != ST_IDLE);

  always_comb begin
    func_legal = 1'b0;
    case (alu_ctrl[5:0])
      6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A: func_legal = 1'b1;
      default:                                  func_legal = 1'b0;
    endcase
  end

  // Only R-type ops (aluop 2'b10) carry a func field that can be illegal.
  assign cap_err = (alu_ctrl[7:6] == 2'b10) & ~func_legal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      rr_ptr     <= 1'b0;
      cnt        <= '0;
      id_q       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            alu_a    <= gnt_id ? req1_a    : req0_a;
            alu_b    <= gnt_id ? req1_b    : req0_b;
            alu_ctrl <= gnt_id ? req1_ctrl : req0_ctrl;
            id_q     <= gnt_id;
            cnt      <= CNT_INIT;
            rr_ptr   <= ~gnt_id;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            rsp_valid  <= 1'b1;
            rsp_id     <= id_q;
            rsp_err    <= cap_err;
            rsp_result <= cap_err ? '0 : alu_result;
            rsp_zero   <= cap_err ? 1'b0 : alu_zero;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          // The handshake cycle itself never grants; the next op starts from IDLE.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
// Two instances (OP_LATENCY 1 and 3) share stimulus; a behavioural ALU feeds both.
module tb_alu_share_arbiter;
  localparam int L1 = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0v, r1v, rsp_rdy;
  logic [31:0] r0a, r0b, r1a, r1b;
  logic [7:0]  r0c, r1c;

  logic        d1_r0rdy, d1_r1rdy, d1_rv, d1_rid, d1_rzero, d1_rerr, d1_busy, d1_az;
  logic [31:0] d1_aa, d1_ab, d1_res, d1_rres;
  logic [7:0]  d1_ac;
  logic        d3_r0rdy, d3_r1rdy, d3_rv, d3_rid, d3_rzero, d3_rerr, d3_busy, d3_az;
  logic [31:0] d3_aa, d3_ab, d3_res, d3_rres;
  logic [7:0]  d3_ac;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Behavioural ALU; an illegal func returns junk with zero set so forcing to 0 is visible.
  function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [7:0] c);
    logic [31:0] r;
    logic bad;
    bad = 1'b0;
    case (c[7:6])
      2'b01: r = a - b;
      2'b10: begin
        case (c[5:0])
          6'h20: r = a + b;
          6'h22: r = a - b;
          6'h24: r = a & b;
          6'h25: r = a | b;
          6'h27: r = ~(a | b);
          6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin r = 32'hDEADBEEF; bad = 1'b1; end
        endcase
      end
      default: r = a + b;
    endcase
    return {bad ? 1'b1 : (r == 32'd0), r};
  endfunction

  // Expected response {err, zero, result} for an op.
  function automatic logic [33:0] exp_rsp(input logic [31:0] a, input logic [31:0] b, input logic [7:0] c);
    if (c[7:6] == 2'b10 && !(c[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A}))
      return {2'b10, 32'd0};
    return {1'b0, alu_fn(a, b, c)};
  endfunction

  assign {d1_az, d1_res} = alu_fn(d1_aa, d1_ab, d1_ac);
  assign {d3_az, d3_res} = alu_fn(d3_aa, d3_ab, d3_ac);

  alu_share_arbiter #(.DATA_W(32), .CTRL_W(8), .OP_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req0_valid(r0v), .req0_ready(d1_r0rdy), .req0_a(r0a), .req0_b(r0b), .req0_ctrl(r0c),
    .req1_valid(r1v), .req1_ready(d1_r1rdy), .req1_a(r1a), .req1_b(r1b), .req1_ctrl(r1c),
    .alu_a(d1_aa), .alu_b(d1_ab), .alu_ctrl(d1_ac), .alu_result(d1_res), .alu_zero(d1_az),
    .rsp_valid(d1_rv), .rsp_ready(rsp_rdy), .rsp_id(d1_rid), .rsp_result(d1_rres),
    .rsp_zero(d1_rzero), .rsp_err(d1_rerr), .busy(d1_busy)
  );

  alu_share_arbiter #(.DATA_W(32), .CTRL_W(8), .OP_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .req0_valid(r0v), .req0_ready(d3_r0rdy), .req0_a(r0a), .req0_b(r0b), .req0_ctrl(r0c),
    .req1_valid(r1v), .req1_ready(d3_r1rdy), .req1_a(r1a), .req1_b(r1b), .req1_ctrl(r1c),
    .alu_a(d3_aa), .alu_b(d3_ab), .alu_ctrl(d3_ac), .alu_result(d3_res), .alu_zero(d3_az),
    .rsp_valid(d3_rv), .rsp_ready(rsp_rdy), .rsp_id(d3_rid), .rsp_result(d3_rres),
    .rsp_zero(d3_rzero), .rsp_err(d3_rerr), .busy(d3_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_req(input logic id, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [7:0] c);
    if (id) begin r1v = v; r1a = a; r1b = b; r1c = c; end
    else    begin r0v = v; r0a = a; r0b = b; r0c = c; end
  endtask

  task automatic do_reset();
    reset = 1'b1; r0v = 1'b0; r1v = 1'b0; rsp_rdy = 1'b0;
    repeat (2) tick();
    settle();
    check("reset_d1", {d1_aa, d1_ab, d1_ac, d1_rv, d1_rid, d1_rzero, d1_rerr, d1_busy, d1_r0rdy, d1_r1rdy}, 64'd0);
    check("reset_d1_res", d1_rres, 0);
    check("reset_d3", {d3_aa, d3_ab, d3_ac, d3_rv, d3_rid, d3_rzero, d3_rerr, d3_busy, d3_r0rdy, d3_r1rdy}, 64'd0);
    check("reset_d3_res", d3_rres, 0);
    tick();
    reset = 1'b0;
  endtask

  // One op from a lone requester, observed on both latencies with rsp_ready held high.
  task automatic single_op(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [7:0] c,
                           input string tag);
    logic [33:0] e;
    e = exp_rsp(a, b, c);
    rsp_rdy = 1'b1;
    tick(); drive_req(id, 1'b1, a, b, c); settle();
    check({tag, "_ready"}, {d1_r0rdy, d1_r1rdy, d3_r0rdy, d3_r1rdy}, id ? 4'b0101 : 4'b1010);
    tick(); drive_req(id, 1'b0, a, b, c); settle();
    check({tag, "_alu"}, {d1_aa, d1_ab}, {a, b});
    check({tag, "_exec"}, {d1_ac, d1_busy, d1_rv, d1_r0rdy, d1_r1rdy}, {c, 4'b1000});
    tick(); settle();
    check({tag, "_rsp1"}, {d1_rv, d1_rid, d1_rerr, d1_rzero, d1_rres}, {1'b1, id, e});
    check({tag, "_d3wait"}, d3_rv, 0);
    tick(); settle();
    check({tag, "_d1idle"}, {d1_rv, d1_busy, d3_rv, d3_busy}, 4'b0001);
    tick(); settle();
    check({tag, "_rsp3"}, {d3_rv, d3_rid, d3_rerr, d3_rzero, d3_rres}, {1'b1, id, e});
    tick(); settle();
    check({tag, "_d3idle"}, {d3_rv, d3_busy}, 2'b00);
  endtask

  function automatic logic [7:0] rand_ctrl();
    logic [5:0] legal [6];
    legal = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    if ($urandom_range(0, 1) == 0) return {2'($urandom_range(0, 3)), legal[$urandom_range(0, 5)]};
    return 8'($urandom);
  endfunction

  function automatic logic [31:0] rand_word();
    if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 3));
    return $urandom;
  endfunction

  // Reference: one outstanding op; response due OP_LATENCY+1 cycles after grant,
  // free again the cycle after the response is taken; pointer favours the other id after a grant.
  logic        m_out;
  int          m_g;
  logic        m_gid;
  logic [33:0] m_exp;
  logic        m_ptr;
  logic        acc0, acc1;
  int          last_obs;

  task automatic run_engine(input int ncyc, input bit both);
    logic [1:0] er;
    logic gid;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (!r0v || acc0) drive_req(1'b0, both ? 1'b1 : 1'($urandom_range(0, 1)), rand_word(), rand_word(), rand_ctrl());
      if (!r1v || acc1) drive_req(1'b1, both ? 1'b1 : 1'($urandom_range(0, 1)), rand_word(), rand_word(), rand_ctrl());
      acc0 = 1'b0;
      acc1 = 1'b0;
      rsp_rdy = both ? 1'b1 : ($urandom_range(0, 2) != 0);
      settle();
      if (!m_out) begin
        gid = (r0v && r1v) ? m_ptr : r1v;
        er = (r0v || r1v) ? (gid ? 2'b01 : 2'b10) : 2'b00;
        check("eng_ready", {d1_r0rdy, d1_r1rdy}, er);
        check("eng_idle", {d1_busy, d1_rv}, 2'b00);
        if (r0v || r1v) begin
          if (both && last_obs >= 0) check("eng_alternate", d1_r1rdy, (last_obs == 1) ? 0 : 1);
          if (both) last_obs = int'(d1_r1rdy);
          m_out = 1'b1;
          m_g   = cyc;
          m_gid = gid;
          m_exp = gid ? exp_rsp(r1a, r1b, r1c) : exp_rsp(r0a, r0b, r0c);
          m_ptr = ~gid;
          if (gid) acc1 = 1'b1; else acc0 = 1'b1;
        end
      end else begin
        check("eng_busy", {d1_busy, d1_r0rdy, d1_r1rdy}, 3'b100);
        if (cyc < m_g + L1 + 1) begin
          check("eng_wait", d1_rv, 0);
        end else begin
          check("eng_rsp", {d1_rv, d1_rid, d1_rerr, d1_rzero, d1_rres}, {1'b1, m_gid, m_exp});
          if (rsp_rdy) m_out = 1'b0;
        end
      end
    end
  endtask

  initial begin
    logic [35:0] snap;
    reset = 1'b1; r0v = 1'b0; r1v = 1'b0; rsp_rdy = 1'b0;
    r0a = '0; r0b = '0; r0c = '0; r1a = '0; r1b = '0; r1c = '0;
    m_out = 1'b0; m_g = 0; m_gid = 1'b0; m_exp = '0; m_ptr = 1'b0; acc0 = 1'b0; acc1 = 1'b0; last_obs = -1;

    do_reset();

    single_op(1'b0, 32'd5, 32'd3, 8'h20, "add");
    single_op(1'b1, 32'hFFFFFFFF, 32'd1, {2'b10, 6'h2A}, "slt");
    single_op(1'b1, 32'hFFFFFFFF, 32'd1, {2'b10, 6'h3F}, "badfunc");
    single_op(1'b0, 32'd7, 32'd7, 8'h40, "beq");
    single_op(1'b1, 32'h0F0F0000, 32'h00FF00FF, {2'b10, 6'h27}, "nor");

    // Response back-pressure: rsp held, no grants until the pulse, then grant one cycle later.
    rsp_rdy = 1'b0;
    tick(); drive_req(1'b0, 1'b1, 32'd10, 32'd4, 8'h40); settle();
    check("stall_grant", {d1_r0rdy, d1_r1rdy}, 2'b10);
    tick(); r0v = 1'b0; drive_req(1'b1, 1'b1, 32'd2, 32'd2, 8'h20); settle();
    check("stall_exec", {d1_r0rdy, d1_r1rdy}, 2'b00);
    tick(); settle();
    snap = {d1_rv, d1_rid, d1_rerr, d1_rzero, d1_rres};
    check("stall_rsp", snap, {2'b10, exp_rsp(32'd10, 32'd4, 8'h40)});
    for (int k = 0; k < 5; k++) begin
      tick(); settle();
      check("stall_hold", {d1_rv, d1_rid, d1_rerr, d1_rzero, d1_rres}, {2'b10, exp_rsp(32'd10, 32'd4, 8'h40)});
      check("stall_noready", {d1_r0rdy, d1_r1rdy}, 2'b00);
    end
    tick(); rsp_rdy = 1'b1; settle();
    check("stall_hs_noready", {d1_rv, d1_r0rdy, d1_r1rdy}, 3'b100);
    tick(); rsp_rdy = 1'b0; settle();
    check("stall_next_grant", {d1_rv, d1_r0rdy, d1_r1rdy}, 3'b001);
    tick(); r1v = 1'b0; rsp_rdy = 1'b1; settle();
    tick(); settle();
    check("stall_rsp2", {d1_rv, d1_rid, d1_rerr, d1_rzero, d1_rres}, {2'b11, exp_rsp(32'd2, 32'd2, 8'h20)});
    repeat (4) tick();

    // Reset during EXEC aborts the op and restores the pointer to req0.
    tick(); drive_req(1'b0, 1'b1, 32'd1, 32'd1, 8'h20); settle();
    check("abort_grant", {d1_r0rdy, d3_r0rdy}, 2'b11);
    tick(); r0v = 1'b0; reset = 1'b1; settle();
    check("abort_exec", {d1_busy, d3_busy}, 2'b11);
    tick(); reset = 1'b0; settle();
    check("abort_idle", {d1_busy, d1_rv, d3_busy, d3_rv}, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      tick(); settle();
      check("abort_nostale", {d1_rv, d3_rv}, 2'b00);
    end
    drive_req(1'b0, 1'b1, 32'd3, 32'd4, 8'h20);
    drive_req(1'b1, 1'b1, 32'd5, 32'd6, 8'h20);
    #1;
    check("abort_ptr", {d1_r0rdy, d1_r1rdy, d3_r0rdy, d3_r1rdy}, 4'b1010);

    do_reset();
    m_out = 1'b0; m_ptr = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
    run_engine(400, 1'b0);
    run_engine(40, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
